vx_tex_dcache_arb: RTL and testbench

VX_TEX_DCACHE_ARB -- requirements
Module: VX_tex_dcache_arb

---
 rtl/vx_tex_dcache_arb.sv | 252 +++++++++++++++++++++++++
 tb/tb_vx_tex_dcache_arb.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_tex_dcache_arb.sv
`default_nettype none
// ============================================================================
// Module      : vx_tex_dcache_arb
// Description : Two-source (LSU = source 0, TEX = source 1) round-robin
//               arbiter in front of a shared data cache port.
//
//               Request path:
//                 - Whole multi-lane requests are granted.
//                 - The granted request is registered into a single-entry
//                   output buffer, so dcache_req_valid rises one cycle after
//                   the input handshake.
//                 - Each lane tag is extended with the source id as its MSB.
//
//               Response path:
//                 - Responses are steered combinationally by the tag MSB.
//
//               Read-pending limit:
//                 - Each source keeps a count of outstanding reads.
//                 - A source at MAX_PENDING may still issue write-only
//                   requests.
//
// Ports       : clk, reset (synchronous, active-high)
//               lsu_req_* / tex_req_*  : per-source request, ready out
//               lsu_rsp_* / tex_rsp_*  : per-source response, ready in
//               dcache_req_*           : merged request, tag = {src, tag}
//               dcache_rsp_*           : merged response, tag MSB = src
//               perf_lsu_stalls / perf_tex_stalls (only with
//                 TEX_DCACHE_ARB_PERF_EN defined): 44-bit stall-cycle counters
// Macro       : TEX_DCACHE_ARB_PERF_EN - enables the stall perf counters
// Revision    : 1.0 - initial release
// ============================================================================
module vx_tex_dcache_arb #(
    parameter int NUM_REQS    = 4,
    parameter int WORD_SIZE   = 4,
    parameter int TAG_WIDTH   = 8,
    parameter int MAX_PENDING = 8
) (
    input  logic                                           clk,
    input  logic                                           reset,

    // LSU request / response
    input  logic [NUM_REQS-1:0]                            lsu_req_valid,
    input  logic [NUM_REQS-1:0]                            lsu_req_rw,
    input  logic [NUM_REQS*WORD_SIZE-1:0]                  lsu_req_byteen,
    input  logic [NUM_REQS*(32-$clog2(WORD_SIZE))-1:0]     lsu_req_addr,
    input  logic [NUM_REQS*WORD_SIZE*8-1:0]                lsu_req_data,
    input  logic [NUM_REQS*TAG_WIDTH-1:0]                  lsu_req_tag,
    output logic                                           lsu_req_ready,
    output logic                                           lsu_rsp_valid,
    output logic [NUM_REQS-1:0]                            lsu_rsp_tmask,
    output logic [NUM_REQS*WORD_SIZE*8-1:0]                lsu_rsp_data,
    output logic [TAG_WIDTH-1:0]                           lsu_rsp_tag,
    input  logic                                           lsu_rsp_ready,

    // TEX request / response
    input  logic [NUM_REQS-1:0]                            tex_req_valid,
    input  logic [NUM_REQS-1:0]                            tex_req_rw,
    input  logic [NUM_REQS*WORD_SIZE-1:0]                  tex_req_byteen,
    input  logic [NUM_REQS*(32-$clog2(WORD_SIZE))-1:0]     tex_req_addr,
    input  logic [NUM_REQS*WORD_SIZE*8-1:0]                tex_req_data,
    input  logic [NUM_REQS*TAG_WIDTH-1:0]                  tex_req_tag,
    output logic                                           tex_req_ready,
    output logic                                           tex_rsp_valid,
    output logic [NUM_REQS-1:0]                            tex_rsp_tmask,
    output logic [NUM_REQS*WORD_SIZE*8-1:0]                tex_rsp_data,
    output logic [TAG_WIDTH-1:0]                           tex_rsp_tag,
    input  logic                                           tex_rsp_ready,

    // Merged dcache request / response
    output logic                                           dcache_req_valid,
    output logic [NUM_REQS-1:0]                            dcache_req_rw,
    output logic [NUM_REQS*WORD_SIZE-1:0]                  dcache_req_byteen,
    output logic [NUM_REQS*(32-$clog2(WORD_SIZE))-1:0]     dcache_req_addr,
    output logic [NUM_REQS*WORD_SIZE*8-1:0]                dcache_req_data,
    output logic [NUM_REQS*(TAG_WIDTH+1)-1:0]              dcache_req_tag,
    input  logic                                           dcache_req_ready,
    input  logic                                           dcache_rsp_valid,
    input  logic [NUM_REQS-1:0]                            dcache_rsp_tmask,
    input  logic [NUM_REQS*WORD_SIZE*8-1:0]                dcache_rsp_data,
    input  logic [TAG_WIDTH:0]                             dcache_rsp_tag,
    output logic                                           dcache_rsp_ready
`ifdef TEX_DCACHE_ARB_PERF_EN
    ,
    output logic [43:0]                                    perf_tex_stalls,
    output logic [43:0]                                    perf_lsu_stalls
`endif
);

    localparam int c_aw = 32 - $clog2(WORD_SIZE);
    localparam int c_cw = $clog2(MAX_PENDING + 1);
    localparam logic [c_cw-1:0] c_max_pend = c_cw'(MAX_PENDING);

    // ------------------------------------------------------------------
    // Request qualification and arbitration
    // ------------------------------------------------------------------
    logic [c_cw-1:0] r_lsu_pend;
    logic [c_cw-1:0] r_tex_pend;
    logic            r_last_grant;   // 1 = TEX was granted last
    logic            r_out_valid;

    logic w_lsu_has_rd, w_tex_has_rd;
    logic w_lsu_req, w_tex_req;
    logic w_can_load, w_grant_tex;
    logic w_lsu_fire, w_tex_fire;

    assign w_lsu_has_rd = |(lsu_req_valid & ~lsu_req_rw);
    assign w_tex_has_rd = |(tex_req_valid & ~tex_req_rw);

    // The pending limit only gates requests that carry at least one read lane
    assign w_lsu_req = (|lsu_req_valid) && (!w_lsu_has_rd || (r_lsu_pend < c_max_pend));
    assign w_tex_req = (|tex_req_valid) && (!w_tex_has_rd || (r_tex_pend < c_max_pend));

    // Buffer may load when empty or when it is draining this very cycle
    assign w_can_load  = !r_out_valid || dcache_req_ready;

    // TEX wins when alone, or when both request and LSU was granted last
    assign w_grant_tex = w_tex_req && (!w_lsu_req || !r_last_grant);

    assign w_lsu_fire  = !reset && w_can_load && w_lsu_req && !w_grant_tex;
    assign w_tex_fire  = !reset && w_can_load && w_grant_tex;

    assign lsu_req_ready = w_lsu_fire;
    assign tex_req_ready = w_tex_fire;

    // ------------------------------------------------------------------
    // Request mux and tag extension
    // ------------------------------------------------------------------
    logic [NUM_REQS-1:0]               w_sel_rw;
    logic [NUM_REQS*WORD_SIZE-1:0]     w_sel_byteen;
    logic [NUM_REQS*c_aw-1:0]          w_sel_addr;
    logic [NUM_REQS*WORD_SIZE*8-1:0]   w_sel_data;
    logic [NUM_REQS*(TAG_WIDTH+1)-1:0] w_sel_tag;

    assign w_sel_rw     = w_grant_tex ? tex_req_rw     : lsu_req_rw;
    assign w_sel_byteen = w_grant_tex ? tex_req_byteen : lsu_req_byteen;
    assign w_sel_addr   = w_grant_tex ? tex_req_addr   : lsu_req_addr;
    assign w_sel_data   = w_grant_tex ? tex_req_data   : lsu_req_data;

    generate
        for (genvar i = 0; i < NUM_REQS; i++) begin : g_tag
            assign w_sel_tag[i*(TAG_WIDTH+1) +: (TAG_WIDTH+1)] = w_grant_tex
                ? {1'b1, tex_req_tag[i*TAG_WIDTH +: TAG_WIDTH]}
                : {1'b0, lsu_req_tag[i*TAG_WIDTH +: TAG_WIDTH]};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Single-entry output buffer
    // ------------------------------------------------------------------
    logic [NUM_REQS-1:0]               r_out_rw;
    logic [NUM_REQS*WORD_SIZE-1:0]     r_out_byteen;
    logic [NUM_REQS*c_aw-1:0]          r_out_addr;
    logic [NUM_REQS*WORD_SIZE*8-1:0]   r_out_data;
    logic [NUM_REQS*(TAG_WIDTH+1)-1:0] r_out_tag;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_can_load) begin
            r_out_valid <= w_lsu_fire || w_tex_fire;
            if (w_lsu_fire || w_tex_fire) begin
                r_out_rw     <= w_sel_rw;
                r_out_byteen <= w_sel_byteen;
                r_out_addr   <= w_sel_addr;
                r_out_data   <= w_sel_data;
                r_out_tag    <= w_sel_tag;
                r_last_grant <= w_tex_fire;
            end
        end
    end

    assign dcache_req_valid  = r_out_valid;
    assign dcache_req_rw     = r_out_rw;
    assign dcache_req_byteen = r_out_byteen;
    assign dcache_req_addr   = r_out_addr;
    assign dcache_req_data   = r_out_data;
    assign dcache_req_tag    = r_out_tag;

    // ------------------------------------------------------------------
    // Response routing by tag MSB
    // ------------------------------------------------------------------
    logic w_rsp_src;
    logic w_lsu_rsp_fire, w_tex_rsp_fire;

    assign w_rsp_src        = dcache_rsp_tag[TAG_WIDTH];

    assign lsu_rsp_valid    = dcache_rsp_valid && !w_rsp_src;
    assign lsu_rsp_tmask    = dcache_rsp_tmask;
    assign lsu_rsp_data     = dcache_rsp_data;
    assign lsu_rsp_tag      = dcache_rsp_tag[TAG_WIDTH-1:0];

    assign tex_rsp_valid    = dcache_rsp_valid && w_rsp_src;
    assign tex_rsp_tmask    = dcache_rsp_tmask;
    assign tex_rsp_data     = dcache_rsp_data;
    assign tex_rsp_tag      = dcache_rsp_tag[TAG_WIDTH-1:0];

    assign dcache_rsp_ready = w_rsp_src ? tex_rsp_ready : lsu_rsp_ready;

    assign w_lsu_rsp_fire   = lsu_rsp_valid && lsu_rsp_ready;
    assign w_tex_rsp_fire   = tex_rsp_valid && tex_rsp_ready;

    // ------------------------------------------------------------------
    // Outstanding-read counters (saturating at both ends)
    // ------------------------------------------------------------------
    logic w_lsu_inc, w_tex_inc;

    assign w_lsu_inc = w_lsu_fire && w_lsu_has_rd;
    assign w_tex_inc = w_tex_fire && w_tex_has_rd;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lsu_pend <= '0;
            r_tex_pend <= '0;
        end else begin
            if (w_lsu_inc && !w_lsu_rsp_fire && (r_lsu_pend != c_max_pend))
                r_lsu_pend <= r_lsu_pend + c_cw'(1);
            else if (!w_lsu_inc && w_lsu_rsp_fire && (r_lsu_pend != '0))
                r_lsu_pend <= r_lsu_pend - c_cw'(1);

            if (w_tex_inc && !w_tex_rsp_fire && (r_tex_pend != c_max_pend))
                r_tex_pend <= r_tex_pend + c_cw'(1);
            else if (!w_tex_inc && w_tex_rsp_fire && (r_tex_pend != '0))
                r_tex_pend <= r_tex_pend - c_cw'(1);
        end
    end

`ifdef TEX_DCACHE_ARB_PERF_EN
    // ------------------------------------------------------------------
    // Stall counters: cycles with a valid request that is not accepted
    // ------------------------------------------------------------------
    logic [43:0] r_perf_lsu_stalls;
    logic [43:0] r_perf_tex_stalls;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_lsu_stalls <= '0;
            r_perf_tex_stalls <= '0;
        end else begin
            if ((|lsu_req_valid) && !lsu_req_ready)
                r_perf_lsu_stalls <= r_perf_lsu_stalls + 44'd1;
            if ((|tex_req_valid) && !tex_req_ready)
                r_perf_tex_stalls <= r_perf_tex_stalls + 44'd1;
        end
    end

    assign perf_lsu_stalls = r_perf_lsu_stalls;
    assign perf_tex_stalls = r_perf_tex_stalls;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vx_tex_dcache_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_vx_tex_dcache_arb
// Description : Self-checking bench for vx_tex_dcache_arb (NUM_REQS=2,
//               WORD_SIZE=4, TAG_WIDTH=8, MAX_PENDING=2). Response routing is
//               table driven; arbitration, stall, pending-limit and reset
//               behaviour use directed sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vx_tex_dcache_arb;

    localparam int NR = 2;
    localparam int WS = 4;
    localparam int TW = 8;
    localparam int MP = 2;
    localparam int AW = 30;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [NR-1:0]      lsu_req_valid, lsu_req_rw, tex_req_valid, tex_req_rw;
    logic [NR*WS-1:0]   lsu_req_byteen, tex_req_byteen;
    logic [NR*AW-1:0]   lsu_req_addr, tex_req_addr;
    logic [NR*WS*8-1:0] lsu_req_data, tex_req_data;
    logic [NR*TW-1:0]   lsu_req_tag, tex_req_tag;
    logic               lsu_req_ready, tex_req_ready;
    logic               lsu_rsp_valid, tex_rsp_valid;
    logic [NR-1:0]      lsu_rsp_tmask, tex_rsp_tmask;
    logic [NR*WS*8-1:0] lsu_rsp_data, tex_rsp_data;
    logic [TW-1:0]      lsu_rsp_tag, tex_rsp_tag;
    logic               lsu_rsp_ready, tex_rsp_ready;
    logic               dcache_req_valid, dcache_req_ready;
    logic [NR-1:0]      dcache_req_rw;
    logic [NR*WS-1:0]   dcache_req_byteen;
    logic [NR*AW-1:0]   dcache_req_addr;
    logic [NR*WS*8-1:0] dcache_req_data;
    logic [NR*(TW+1)-1:0] dcache_req_tag;
    logic               dcache_rsp_valid, dcache_rsp_ready;
    logic [NR-1:0]      dcache_rsp_tmask;
    logic [NR*WS*8-1:0] dcache_rsp_data;
    logic [TW:0]        dcache_rsp_tag;
`ifdef TEX_DCACHE_ARB_PERF_EN
    logic [43:0]        perf_tex_stalls, perf_lsu_stalls;
`endif

    vx_tex_dcache_arb #(
        .NUM_REQS(NR), .WORD_SIZE(WS), .TAG_WIDTH(TW), .MAX_PENDING(MP)
    ) dut (
        .clk(clk), .reset(reset),
        .lsu_req_valid(lsu_req_valid), .lsu_req_rw(lsu_req_rw),
        .lsu_req_byteen(lsu_req_byteen), .lsu_req_addr(lsu_req_addr),
        .lsu_req_data(lsu_req_data), .lsu_req_tag(lsu_req_tag),
        .lsu_req_ready(lsu_req_ready),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_tmask(lsu_rsp_tmask),
        .lsu_rsp_data(lsu_rsp_data), .lsu_rsp_tag(lsu_rsp_tag),
        .lsu_rsp_ready(lsu_rsp_ready),
        .tex_req_valid(tex_req_valid), .tex_req_rw(tex_req_rw),
        .tex_req_byteen(tex_req_byteen), .tex_req_addr(tex_req_addr),
        .tex_req_data(tex_req_data), .tex_req_tag(tex_req_tag),
        .tex_req_ready(tex_req_ready),
        .tex_rsp_valid(tex_rsp_valid), .tex_rsp_tmask(tex_rsp_tmask),
        .tex_rsp_data(tex_rsp_data), .tex_rsp_tag(tex_rsp_tag),
        .tex_rsp_ready(tex_rsp_ready),
        .dcache_req_valid(dcache_req_valid), .dcache_req_rw(dcache_req_rw),
        .dcache_req_byteen(dcache_req_byteen), .dcache_req_addr(dcache_req_addr),
        .dcache_req_data(dcache_req_data), .dcache_req_tag(dcache_req_tag),
        .dcache_req_ready(dcache_req_ready),
        .dcache_rsp_valid(dcache_rsp_valid), .dcache_rsp_tmask(dcache_rsp_tmask),
        .dcache_rsp_data(dcache_rsp_data), .dcache_rsp_tag(dcache_rsp_tag),
        .dcache_rsp_ready(dcache_rsp_ready)
`ifdef TEX_DCACHE_ARB_PERF_EN
        , .perf_tex_stalls(perf_tex_stalls), .perf_lsu_stalls(perf_lsu_stalls)
`endif
    );

    // Expected merged tags: lane1 in the upper half, source id as each lane MSB
    localparam logic [NR*(TW+1)-1:0] c_lsu_tag = {1'b0, 8'h12, 1'b0, 8'h11};
    localparam logic [NR*(TW+1)-1:0] c_tex_tag = {1'b1, 8'h22, 1'b1, 8'h21};
    localparam logic [NR*AW-1:0]     c_lsu_addr = {30'h101, 30'h100};
    localparam logic [NR*AW-1:0]     c_tex_addr = {30'h201, 30'h200};

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic       rsp_v;
        logic [8:0] rsp_tag;
        logic       lsu_rdy;
        logic       tex_rdy;
        logic       e_lsu_v;
        logic       e_tex_v;
        logic [7:0] e_tag;
        logic       e_dc_rdy;
    } rsp_vec_t;

    rsp_vec_t vecs [5];

    initial begin
        vecs[0] = '{1'b1, 9'h1A5, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0};
        vecs[1] = '{1'b1, 9'h1A5, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1};
        vecs[2] = '{1'b1, 9'h03C, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b1};
        vecs[3] = '{1'b1, 9'h03C, 1'b0, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b0};
        vecs[4] = '{1'b0, 9'h1FF, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b1};

        lsu_req_valid = '0; lsu_req_rw = '0; lsu_req_byteen = '1;
        lsu_req_addr = c_lsu_addr; lsu_req_data = 64'h1111_2222_3333_4444;
        lsu_req_tag = {8'h12, 8'h11};
        tex_req_valid = '0; tex_req_rw = '0; tex_req_byteen = '1;
        tex_req_addr = c_tex_addr; tex_req_data = 64'h5555_6666_7777_8888;
        tex_req_tag = {8'h22, 8'h21};
        lsu_rsp_ready = 1'b1; tex_rsp_ready = 1'b1;
        dcache_req_ready = 1'b1; dcache_rsp_valid = 1'b0;
        dcache_rsp_tmask = 2'b10; dcache_rsp_data = 64'hCAFE_F00D_1234_5678;
        dcache_rsp_tag = '0;

        // ---------------- reset with both sources presenting writes
        reset = 1'b1;
        lsu_req_valid = 2'b11; lsu_req_rw = 2'b11;
        tex_req_valid = 2'b11; tex_req_rw = 2'b11;
        tick();
        chk("reset_req_valid", 64'(dcache_req_valid), 64'd0);
        chk("reset_lsu_ready", 64'(lsu_req_ready), 64'd0);
        chk("reset_tex_ready", 64'(tex_req_ready), 64'd0);
        reset = 1'b0;
        lsu_req_valid = '0; tex_req_valid = '0;
        tick();

        // ---------------- contested writes, dcache always ready: L,T,L,T
        lsu_req_valid = 2'b11; tex_req_valid = 2'b11;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("rr_lsu_ready", 64'(lsu_req_ready), 64'((i % 2) == 0));
            chk("rr_tex_ready", 64'(tex_req_ready), 64'((i % 2) == 1));
            if (i > 0) begin
                chk("rr_out_valid", 64'(dcache_req_valid), 64'd1);
                chk("rr_out_tag", 64'(dcache_req_tag), ((i % 2) == 1) ? 64'(c_lsu_tag) : 64'(c_tex_tag));
            end
            tick();
        end
        chk("rr_out_valid", 64'(dcache_req_valid), 64'd1);
        chk("rr_last_tag", 64'(dcache_req_tag), 64'(c_tex_tag));
        lsu_req_valid = '0; tex_req_valid = '0;
        tick();
        chk("rr_drained", 64'(dcache_req_valid), 64'd0);

        // ---------------- backpressure: buffer holds, no bubble on release
        lsu_req_valid = 2'b11; tex_req_valid = 2'b11; dcache_req_ready = 1'b0;
        #1;
        chk("bp_first_lsu_ready", 64'(lsu_req_ready), 64'd1);
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("bp_lsu_ready", 64'(lsu_req_ready), 64'd0);
            chk("bp_tex_ready", 64'(tex_req_ready), 64'd0);
            chk("bp_valid_held", 64'(dcache_req_valid), 64'd1);
            chk("bp_addr_held", 64'(dcache_req_addr), 64'(c_lsu_addr));
            chk("bp_tag_held", 64'(dcache_req_tag), 64'(c_lsu_tag));
            tick();
        end
        dcache_req_ready = 1'b1;
        #1;
        chk("bp_release_tex_ready", 64'(tex_req_ready), 64'd1);
        chk("bp_release_lsu_ready", 64'(lsu_req_ready), 64'd0);
        tick();
        chk("bp_next_valid", 64'(dcache_req_valid), 64'd1);
        chk("bp_next_addr", 64'(dcache_req_addr), 64'(c_tex_addr));
        lsu_req_valid = '0; tex_req_valid = '0;
        tick();
        chk("bp_drained", 64'(dcache_req_valid), 64'd0);

        // ---------------- response routing table (counters at 0 hold at 0)
        for (int v = 0; v < 5; v++) begin
            dcache_rsp_valid = vecs[v].rsp_v;
            dcache_rsp_tag   = vecs[v].rsp_tag;
            lsu_rsp_ready    = vecs[v].lsu_rdy;
            tex_rsp_ready    = vecs[v].tex_rdy;
            #1;
            chk("rsp_lsu_valid", 64'(lsu_rsp_valid), 64'(vecs[v].e_lsu_v));
            chk("rsp_tex_valid", 64'(tex_rsp_valid), 64'(vecs[v].e_tex_v));
            chk("rsp_lsu_tag", 64'(lsu_rsp_tag), 64'(vecs[v].e_tag));
            chk("rsp_tex_tag", 64'(tex_rsp_tag), 64'(vecs[v].e_tag));
            chk("rsp_dc_ready", 64'(dcache_rsp_ready), 64'(vecs[v].e_dc_rdy));
            chk("rsp_tmask", 64'(vecs[v].e_tex_v ? tex_rsp_tmask : lsu_rsp_tmask), 64'h2);
            chk("rsp_data", vecs[v].e_tex_v ? tex_rsp_data : lsu_rsp_data, 64'hCAFE_F00D_1234_5678);
            tick();
        end
        dcache_rsp_valid = 1'b0; lsu_rsp_ready = 1'b1; tex_rsp_ready = 1'b1;
        tick();

        // ---------------- TEX pending limit (MAX_PENDING=2)
        tex_req_valid = 2'b11; tex_req_rw = 2'b00;
        #1;
        chk("pend_tex_rd1", 64'(tex_req_ready), 64'd1);
        tick();
        chk("pend_tex_rd2", 64'(tex_req_ready), 64'd1);
        tick();
        chk("pend_tex_rd3_stall", 64'(tex_req_ready), 64'd0);
        tex_req_rw = 2'b11;
        #1;
        chk("pend_tex_wr_pass", 64'(tex_req_ready), 64'd1);
        tick();
        tex_req_rw = 2'b01;   // lane 1 is a read
        #1;
        chk("pend_tex_mixed_stall", 64'(tex_req_ready), 64'd0);
        dcache_rsp_valid = 1'b1; dcache_rsp_tag = 9'h1A5;
        #1;
        chk("pend_tex_rsp_same_cycle", 64'(tex_req_ready), 64'd0);
        tick();
        dcache_rsp_valid = 1'b0;
        #1;
        chk("pend_tex_after_rsp", 64'(tex_req_ready), 64'd1);
        tick();
        chk("pend_tex_full_again", 64'(tex_req_ready), 64'd0);
        tex_req_valid = '0;
        dcache_rsp_valid = 1'b1; dcache_rsp_tag = 9'h100;
        tick(); tick();
        dcache_rsp_valid = 1'b0;
        tick();

        // ---------------- LSU simultaneous increment/decrement at count 1
        lsu_req_valid = 2'b11; lsu_req_rw = 2'b00;
        #1;
        chk("simul_lsu_rd1", 64'(lsu_req_ready), 64'd1);
        tick();
        dcache_rsp_valid = 1'b1; dcache_rsp_tag = 9'h033;
        #1;
        chk("simul_lsu_rd2", 64'(lsu_req_ready), 64'd1);
        chk("simul_dc_rsp_ready", 64'(dcache_rsp_ready), 64'd1);
        tick();
        dcache_rsp_valid = 1'b0;
        #1;
        chk("simul_lsu_rd3", 64'(lsu_req_ready), 64'd1);
        tick();
        chk("simul_lsu_stall", 64'(lsu_req_ready), 64'd0);
        lsu_req_valid = '0;
        dcache_rsp_valid = 1'b1; dcache_rsp_tag = 9'h000;
        tick(); tick();
        dcache_rsp_valid = 1'b0;
        tick();

        // ---------------- reset while buffer full and counters non-zero
        tex_req_valid = 2'b11; tex_req_rw = 2'b00;
        tick(); tick();       // TEX pending -> 2
        tex_req_valid = '0;
        lsu_req_valid = 2'b11; lsu_req_rw = 2'b00;
        #1;
        chk("rst_pre_lsu_rd", 64'(lsu_req_ready), 64'd1);
        tick();               // LSU pending -> 1, last grant = LSU
        dcache_req_ready = 1'b0;
        lsu_req_rw = 2'b11; tex_req_valid = 2'b11; tex_req_rw = 2'b11;
        #1;
        chk("rst_pre_full_lsu", 64'(lsu_req_ready), 64'd0);
        chk("rst_pre_full_tex", 64'(tex_req_ready), 64'd0);
        tick();
        chk("rst_pre_valid", 64'(dcache_req_valid), 64'd1);
        reset = 1'b1;
        #1;
        chk("rst_cycle_lsu_ready", 64'(lsu_req_ready), 64'd0);
        chk("rst_cycle_tex_ready", 64'(tex_req_ready), 64'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("rst_post_valid", 64'(dcache_req_valid), 64'd0);
        chk("rst_post_lsu_wins", 64'(lsu_req_ready), 64'd1);
        chk("rst_post_tex_loses", 64'(tex_req_ready), 64'd0);
        tick();
        chk("rst_post_out_valid", 64'(dcache_req_valid), 64'd1);
        chk("rst_post_out_tag", 64'(dcache_req_tag), 64'(c_lsu_tag));
        lsu_req_valid = '0; tex_req_valid = '0; dcache_req_ready = 1'b1;
        tick();
        tex_req_valid = 2'b11; tex_req_rw = 2'b00;
        #1;
        chk("rst_tex_cnt_rd1", 64'(tex_req_ready), 64'd1);
        tick();
        chk("rst_tex_cnt_rd2", 64'(tex_req_ready), 64'd1);
        tick();
        chk("rst_tex_cnt_stall", 64'(tex_req_ready), 64'd0);
        tex_req_valid = '0;
        lsu_req_valid = 2'b11; lsu_req_rw = 2'b00;
        #1;
        chk("rst_lsu_cnt_rd1", 64'(lsu_req_ready), 64'd1);
        tick();
        chk("rst_lsu_cnt_rd2", 64'(lsu_req_ready), 64'd1);
        tick();
        chk("rst_lsu_cnt_stall", 64'(lsu_req_ready), 64'd0);
        lsu_req_valid = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
